ins_decoder: RTL
================

# ins_decoder

Buffered instruction decode stage for the 31-instruction MIPS core. It sits between instruction memory and the combinational control unit. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake and decodes each one into the one-hot `ins` vector that the control unit consumes. Decoded entries are held in a small FIFO, so fetch can run ahead while the datapath stalls, and a flush discards wrong-path instructions on taken branches and jumps.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_instr` and `in_pc` are valid.
- `in_ready` out 1: the buffer can accept a word this cycle.
- `in_instr` in 32: raw instruction word from IM.
- `in_pc` in 32: PC of `in_instr`.
- `flush` in 1: discard all buffered entries and any incoming word this cycle.
- `out_valid` out 1: the head entry is valid.
- `out_ready` in 1: the consumer takes the head this cycle.
- `out_ins` out 32: one-hot decode of the head entry; bit 31 is always 0.
- `out_instr` out 32: raw head word, passed through for register and immediate fields.
- `out_pc` out 32: head PC.
- `out_illegal` out 1: the head word matched no supported instruction; `out_ins` is 0.

## Operation
- One-hot index mapping:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu
  - 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr
  - 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne
  - 26 slti, 27 sltiu, 28 lui, 29 j, 30 jal
- R-type instructions have opcode `instr[31:26]` = 0x00 and are selected by funct `instr[5:0]`:
  - add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27
  - slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07, jr 0x08
- Other instructions are selected by opcode:
  - addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D, xori 0x0E
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, slti 0x0A, sltiu 0x0B, lui 0x0F, j 0x02, jal 0x03
- Decode examines only opcode and funct. The shamt, rs, rt and rd fields are never checked.
- Any unmatched opcode or funct gives `ins` = 0 and illegal = 1. The word is still enqueued and delivered; it is not dropped.
- Decode happens on the input side. The FIFO stores {ins[30:0], illegal, instr, pc}, and the outputs are driven directly from the head entry registers.
- Push condition: `in_valid & in_ready & ~flush`.
- Pop condition: `out_valid & out_ready & ~flush`.
- `in_ready` = `count != DEPTH`. It depends only on registered state, with no combinational path from `out_ready`.
- `out_valid` = `count != 0`.
- When push and pop occur in the same cycle while full, the push is refused because `in_ready` is 0; the pop proceeds.
- Flush:
  - Next cycle `count` = 0 and `out_valid` = 0.
  - Same-cycle push and pop are ignored.
  - `in_ready` is 1 the next cycle.

## Timing
- Latency: a word accepted at edge N appears at the outputs after edge N, so `out_valid` = 1 in cycle N+1 if the buffer was empty.
- Throughput: one word per cycle in steady state when `out_ready` is held at 1.
- While `out_valid` = 1 and `out_ready` = 0, all `out_*` outputs hold stable.
- Reset values:
  - `count` = 0, read and write pointers = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - `out_ins` = 0, `out_instr` = 0, `out_pc` = 0, `out_illegal` = 0, with entry storage cleared.
- Reset mid-stream behaves like flush plus clearing of storage.
- `rst` has priority over `flush`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.

## Structure
- Shared package `mips_pkg` holds:
  - the one-hot index localparams (`INS_ADD`…`INS_JAL`);
  - the opcode and funct constants;
  - the `NUM_INS` = 31 constant.
- Sub-module `ins_onehot_dec`: combinational word → {ins[31:0], illegal}. It is reused by the test bench reference model.
- The top level holds the FIFO storage, pointers, count and handshake logic.

## Test plan
- After reset, push 0x00221820 (add) with pc 0x00400000 → next cycle `out_valid` = 1, `out_ins` = 0x00000001, `out_pc` = 0x00400000, `out_illegal` = 0.
- Stream 0x8C220004 (lw), 0xAC220004 (sw), 0x0C000010 (jal) with `out_ready` = 1 → `out_ins` = 0x00400000, 0x00800000, 0x40000000 on consecutive cycles, with no bubbles.
- Push 0xFC000000 and 0x0000003F → both delivered with `out_ins` = 0 and `out_illegal` = 1.
- Hold `out_ready` = 0 and push three words → `in_ready` = 0 after the second; the third is held off; the head stays stable. Then release → order is preserved.
- Two entries buffered, assert `flush` together with `in_valid` → next cycle `out_valid` = 0 and `in_ready` = 1; the flushed-cycle word never appears.
- Assert `rst` while full and popping → next cycle all outputs are at their reset values and `count` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS instruction indices, opcodes and funct codes
package mips_pkg;

    localparam int NUM_INS = 31;

    localparam int INS_ADD   = 0;
    localparam int INS_ADDU  = 1;
    localparam int INS_SUB   = 2;
    localparam int INS_SUBU  = 3;
    localparam int INS_AND   = 4;
    localparam int INS_OR    = 5;
    localparam int INS_XOR   = 6;
    localparam int INS_NOR   = 7;
    localparam int INS_SLT   = 8;
    localparam int INS_SLTU  = 9;
    localparam int INS_SLL   = 10;
    localparam int INS_SRL   = 11;
    localparam int INS_SRA   = 12;
    localparam int INS_SLLV  = 13;
    localparam int INS_SRLV  = 14;
    localparam int INS_SRAV  = 15;
    localparam int INS_JR    = 16;
    localparam int INS_ADDI  = 17;
    localparam int INS_ADDIU = 18;
    localparam int INS_ANDI  = 19;
    localparam int INS_ORI   = 20;
    localparam int INS_XORI  = 21;
    localparam int INS_LW    = 22;
    localparam int INS_SW    = 23;
    localparam int INS_BEQ   = 24;
    localparam int INS_BNE   = 25;
    localparam int INS_SLTI  = 26;
    localparam int INS_SLTIU = 27;
    localparam int INS_LUI   = 28;
    localparam int INS_J     = 29;
    localparam int INS_JAL   = 30;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;

endpackage

// File: rtl/ins_onehot_dec.sv
// rtl/ins_onehot_dec.sv - combinational instruction word to one-hot decode
module ins_onehot_dec
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_ins,
    output logic        o_illegal
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];

    // Only opcode and funct matter; register and shamt fields are ignored.
    always_comb begin
        o_ins = '0;
        if (w_op == OP_RTYPE) begin
            case (w_fn)
                FN_ADD:  o_ins[INS_ADD]  = 1'b1;
                FN_ADDU: o_ins[INS_ADDU] = 1'b1;
                FN_SUB:  o_ins[INS_SUB]  = 1'b1;
                FN_SUBU: o_ins[INS_SUBU] = 1'b1;
                FN_AND:  o_ins[INS_AND]  = 1'b1;
                FN_OR:   o_ins[INS_OR]   = 1'b1;
                FN_XOR:  o_ins[INS_XOR]  = 1'b1;
                FN_NOR:  o_ins[INS_NOR]  = 1'b1;
                FN_SLT:  o_ins[INS_SLT]  = 1'b1;
                FN_SLTU: o_ins[INS_SLTU] = 1'b1;
                FN_SLL:  o_ins[INS_SLL]  = 1'b1;
                FN_SRL:  o_ins[INS_SRL]  = 1'b1;
                FN_SRA:  o_ins[INS_SRA]  = 1'b1;
                FN_SLLV: o_ins[INS_SLLV] = 1'b1;
                FN_SRLV: o_ins[INS_SRLV] = 1'b1;
                FN_SRAV: o_ins[INS_SRAV] = 1'b1;
                FN_JR:   o_ins[INS_JR]   = 1'b1;
                default: o_ins = '0;
            endcase
        end else begin
            case (w_op)
                OP_ADDI:  o_ins[INS_ADDI]  = 1'b1;
                OP_ADDIU: o_ins[INS_ADDIU] = 1'b1;
                OP_ANDI:  o_ins[INS_ANDI]  = 1'b1;
                OP_ORI:   o_ins[INS_ORI]   = 1'b1;
                OP_XORI:  o_ins[INS_XORI]  = 1'b1;
                OP_LW:    o_ins[INS_LW]    = 1'b1;
                OP_SW:    o_ins[INS_SW]    = 1'b1;
                OP_BEQ:   o_ins[INS_BEQ]   = 1'b1;
                OP_BNE:   o_ins[INS_BNE]   = 1'b1;
                OP_SLTI:  o_ins[INS_SLTI]  = 1'b1;
                OP_SLTIU: o_ins[INS_SLTIU] = 1'b1;
                OP_LUI:   o_ins[INS_LUI]   = 1'b1;
                OP_J:     o_ins[INS_J]     = 1'b1;
                OP_JAL:   o_ins[INS_JAL]   = 1'b1;
                default:  o_ins = '0;
            endcase
        end
    end

    assign o_illegal = (o_ins == '0);

endmodule

// File: rtl/ins_decoder.sv
// rtl/ins_decoder.sv - buffered decode stage: decode on input, FIFO of decoded entries
module ins_decoder
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_INS-1:0] r_ins_mem   [DEPTH];
    logic               r_ill_mem   [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];
    logic [31:0]        r_pc_mem    [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:0] w_dec_ins;
    logic        w_dec_ill;
    logic        w_ill_store;
    logic        w_push;
    logic        w_pop;

    ins_onehot_dec u_dec (
        .i_instr   (in_instr),
        .o_ins     (w_dec_ins),
        .o_illegal (w_dec_ill)
    );

    // Bit 31 of the decode is structurally zero, so OR-ing it in never changes illegal.
    assign w_ill_store = w_dec_ill | w_dec_ins[NUM_INS];

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ins_mem[i]   <= '0;
                r_ill_mem[i]   <= 1'b0;
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_ins_mem[r_wr_ptr]   <= w_dec_ins[NUM_INS-1:0];
                r_ill_mem[r_wr_ptr]   <= w_ill_store;
                r_instr_mem[r_wr_ptr] <= in_instr;
                r_pc_mem[r_wr_ptr]    <= in_pc;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign out_ins     = {1'b0, r_ins_mem[r_rd_ptr]};
    assign out_illegal = r_ill_mem[r_rd_ptr];
    assign out_instr   = r_instr_mem[r_rd_ptr];
    assign out_pc      = r_pc_mem[r_rd_ptr];

endmodule
